// File: rtl/psum_accumulator.sv
// Sums NUM_TILES signed row partial sums, then shifts, optionally ReLUs and saturates the total.
// The result is registered one cycle after the last beat. The last beat stalls only while an unconsumed result is held.
module psum_accumulator #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ACC_BW         = 32,
    parameter int OUT_BW         = 8,
    parameter int NUM_TILES      = 4,
    localparam int CNT_BW        = $clog2(NUM_TILES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [PARTIAL_SUM_BW-1:0] in_psum,
    input  logic        [4:0]                shift,
    input  logic                             relu_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [OUT_BW-1:0]         out_data,
    output logic signed [ACC_BW-1:0]         out_acc,
    output logic                             out_sat,
    output logic        [CNT_BW-1:0]         tile_cnt
);

    typedef enum logic {
        ACCUM      = 1'b0,
        ACCUM_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_BW-1:0] LAST_TILE = CNT_BW'(NUM_TILES - 1);
    localparam logic signed [ACC_BW-1:0] Q_MAX =
        {{(ACC_BW - OUT_BW + 1){1'b0}}, {(OUT_BW - 1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] Q_MIN = ~Q_MAX;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_BW-1:0]           r_tile_cnt;
    logic signed [ACC_BW-1:0]    r_acc;
    logic signed [ACC_BW-1:0]    r_out_acc;
    logic signed [OUT_BW-1:0]    r_out_data;
    logic                        r_out_sat;

    logic                        w_last;
    logic                        w_in_fire;
    logic                        w_out_fire;
    logic                        w_last_fire;
    logic signed [ACC_BW-1:0]    w_psum_ext;
    logic signed [ACC_BW-1:0]    w_final;
    logic signed [ACC_BW-1:0]    w_shifted;
    logic signed [ACC_BW-1:0]    w_relu;
    logic signed [OUT_BW-1:0]    w_q_data;
    logic                        w_q_sat;

    assign w_last      = (r_tile_cnt == LAST_TILE);
    assign out_valid   = (r_state == ACCUM_HOLD);
    // Only the last beat needs the output register, so only it can be stalled.
    assign in_ready    = !(w_last && out_valid && !out_ready);
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_last_fire = w_in_fire && w_last;

    assign w_psum_ext = {{(ACC_BW - PARTIAL_SUM_BW){in_psum[PARTIAL_SUM_BW-1]}}, in_psum};
    assign w_final    = (r_tile_cnt == '0) ? w_psum_ext : r_acc + w_psum_ext;

    // ReLU is applied before saturation so a clamp to zero never reports saturation.
    always_comb begin
        w_shifted = w_final >>> shift;
        w_relu    = w_shifted;
        w_q_data  = w_shifted[OUT_BW-1:0];
        w_q_sat   = 1'b0;
        if (relu_en && w_shifted[ACC_BW-1]) begin
            w_relu = '0;
        end
        if (w_relu > Q_MAX) begin
            w_q_data = Q_MAX[OUT_BW-1:0];
            w_q_sat  = 1'b1;
        end else if (w_relu < Q_MIN) begin
            w_q_data = Q_MIN[OUT_BW-1:0];
            w_q_sat  = 1'b1;
        end else begin
            w_q_data = w_relu[OUT_BW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:      if (w_last_fire) w_state_nxt = ACCUM_HOLD;
            ACCUM_HOLD: if (!w_last_fire && w_out_fire) w_state_nxt = ACCUM;
            default:    w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tile_cnt <= '0;
            r_acc      <= '0;
        end else if (w_in_fire) begin
            r_acc      <= w_final;
            r_tile_cnt <= w_last ? '0 : r_tile_cnt + CNT_BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_acc  <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_last_fire) begin
            r_out_acc  <= w_final;
            r_out_data <= w_q_data;
            r_out_sat  <= w_q_sat;
        end
    end

    assign out_acc  = r_out_acc;
    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;
    assign tile_cnt = r_tile_cnt;

endmodule
